tx_frac_bit_timer: RTL
======================

Name: tx_frac_bit_timer

Overview:
- Parametrised next-generation transmit bit timer.
- A Bresenham-style fractional accumulator produces an average of STROBES_DEN shift strobes per CYC_NUM clocks (e.g. 3 per 25) plus an optional mid-bit sample strobe.
- A run-time-programmable bit counter flags frame completion.
- Sits between the TX controller FSM and the TX shift register; supports continuous and one-shot modes and pause/resume.

Parameters:
ACC_W, 8, width of accumulator, cyc_num and strobes_den (CYC_NUM max 2^ACC_W-1)
BIT_CNT_W, 4, width of bit_count and frame_bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable_timer  in  1  start when IDLE, resume when PAUSE
disable_timer  in  1  pause when RUN
clear_timer  in  1  abort to IDLE, zero counters
one_shot  in  1  1: stop after one frame; 0: free-running frames
cyc_num  in  ACC_W  clocks per rate period (numerator)
strobes_den  in  ACC_W  strobes per rate period (denominator)
frame_bits  in  BIT_CNT_W  bits per frame
shift_strobe  out  1  one-cycle pulse per bit period
sample_strobe  out  1  one-cycle pulse at mid-bit
bit_count  out  BIT_CNT_W  strobes issued in current frame
frame_complete  out  1  one-cycle pulse with the strobe that completes the frame
busy  out  1  state != IDLE
cfg_err  out  1  one-cycle pulse, start rejected

Behaviour:
- Decided: one clock, clk; reset rst synchronous, active-high.
- Reset: state=IDLE; acc, bit_count=0; all strobes, frame_complete, cfg_err=0; busy=0.
- All outputs are registered.
- States: IDLE, RUN, PAUSE.
- Per-cycle priority: clear_timer > disable_timer > enable_timer.
- IDLE + enable_timer:
  - Config valid (cyc_num != 0, strobes_den != 0, 2*strobes_den <= cyc_num, frame_bits != 0): latch cyc_num, strobes_den, frame_bits, one_shot; acc=0; bit_count=0; ->RUN.
  - Config invalid: stay IDLE; cfg_err=1 next cycle.
- Config inputs are ignored outside IDLE.
- RUN, each cycle: sum = acc + den, computed ACC_W+1 bits wide.
  - If sum >= num: acc = sum - num; shift_strobe=1 (next cycle).
  - Otherwise: acc = sum.
  - sample_strobe=1 when acc < num>>1 and sum >= num>>1, evaluated before wrap, non-wrapping cycles only.
  - With 2*den <= num, exactly one sample_strobe falls strictly between consecutive shift_strobes.
- On a shift strobe edge:
  - bit_count increments.
  - If the new value == frame_bits: frame_complete=1 on the same edge.
  - If bit_count already == frame_bits: it becomes 1 (continuous rollover; never returns to 0 mid-run).
- one_shot=1: on the frame_complete edge state->IDLE; bit_count holds frame_bits until the next start.
  - enable_timer still high in the next cycle starts a new frame (no dead cycle beyond one).
- RUN + disable_timer: ->PAUSE; acc, bit_count frozen; no strobes.
- PAUSE + enable_timer: ->RUN, continuing from the frozen acc.
- enable_timer in RUN is ignored.
- disable_timer in IDLE/PAUSE is ignored.
- clear_timer in any state: ->IDLE; acc, bit_count=0; strobe outputs forced 0 next cycle. A strobe coinciding with clear is suppressed.
- Simultaneous enable+disable in IDLE: no effect (disable wins by priority and is a no-op in IDLE).
- rst mid-operation: identical to reset values; latched config is discarded.
- Timing for num=25, den=3:
  - Start sampled at edge 0.
  - shift_strobe visible after edges 9, 17, 25, then 34, 42, 50…
  - Intervals 9, 8, 8; exactly 3 per 25 clocks.

Decomposition:
- Package tx_timer_pkg holds:
  - state enum timer_state_t {IDLE, RUN, PAUSE}
  - default localparams DEF_CYC_NUM=25, DEF_STROBES_DEN=3, DEF_FRAME_BITS=8
- One sub-module, frac_rate_accum, is natural:
  - inputs: clk, rst, clr, en, num, den
  - outputs: wrap pulse, half pulse
- Top level holds the FSM, config latch and bit counter.

Test Plan:
- Reset, num=25 den=3 frame_bits=8 one_shot=0, enable pulse -> shift_strobe after edges 9, 17, 25; bit_count 1, 2, 3; frame_complete with 8th strobe at edge 67; bit_count 1 at next strobe.
- num=4 den=1 frame_bits=3 one_shot=1 -> strobes every 4 clocks; sample_strobe 2 clocks after each period start; frame_complete at edge 12; busy=0 after; bit_count holds 3.
- Pause: disable at edge 5, hold 10 cycles, enable -> strobe timing shifted exactly by the pause length; bit_count unchanged during pause.
- clear_timer on the same cycle a strobe would fire -> no strobe; bit_count=0; busy=0; next start restarts at acc=0.
- Invalid configs (den=0; den=13 with num=25; frame_bits=0) + enable -> cfg_err single pulse; busy stays 0.
- rst asserted mid-frame with enable held -> all outputs 0 next cycle; IDLE; a new start after rst deasserts reproduces the 9/17/25 timing.

Source files
------------

// File: rtl/tx_timer_pkg.sv
// tx_timer_pkg: shared state encoding and default rate/frame settings for the TX bit timer
package tx_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} timer_state_t;
  localparam int DEF_CYC_NUM     = 25;
  localparam int DEF_STROBES_DEN = 3;
  localparam int DEF_FRAME_BITS  = 8;
endpackage

// File: rtl/frac_rate_accum.sv
// frac_rate_accum: Bresenham accumulator giving den wraps per num enabled clocks plus a mid-period pulse
module frac_rate_accum #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             wrap,
  output logic             half
);
  logic [ACC_W-1:0] acc_q, acc_d, rem, half_num;
  logic [ACC_W:0]   sum;
  assign sum      = {1'b0, acc_q} + {1'b0, den};
  assign rem      = ACC_W'(sum - {1'b0, num});
  assign half_num = num >> 1;
  assign wrap     = sum >= {1'b0, num};
  assign half     = !wrap && acc_q < half_num && sum >= {1'b0, half_num};
  // Clear dominates; otherwise step by den only when enabled, folding back by num on wrap
  always_comb begin
    acc_d = clr ? '0 : !en ? acc_q : wrap ? rem : sum[ACC_W-1:0];
  end
  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/tx_frac_bit_timer.sv
// tx_frac_bit_timer: fractional-rate TX bit timer with pause/resume, one-shot and frame counting
module tx_frac_bit_timer
  import tx_timer_pkg::*;
#(
  parameter int ACC_W     = 8,
  parameter int BIT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_timer,
  input  logic                 disable_timer,
  input  logic                 clear_timer,
  input  logic                 one_shot,
  input  logic [ACC_W-1:0]     cyc_num,
  input  logic [ACC_W-1:0]     strobes_den,
  input  logic [BIT_CNT_W-1:0] frame_bits,
  output logic                 shift_strobe,
  output logic                 sample_strobe,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic                 frame_complete,
  output logic                 busy,
  output logic                 cfg_err
);
  timer_state_t         state_q, state_d;
  logic [ACC_W-1:0]     num_q, num_d, den_q, den_d;
  logic [BIT_CNT_W-1:0] fb_q, fb_d, bc_q, bc_d, bc_inc;
  logic                 os_q, os_d;
  logic                 shift_q, shift_d, sample_q, sample_d, fc_q, fc_d;
  logic                 cfg_err_q, cfg_err_d, busy_q, busy_d;
  logic                 cfg_ok, idle_go, start, adv, wrap, half;
  assign cfg_ok  = cyc_num != '0 && strobes_den != '0 && frame_bits != '0
                   && ({1'b0, strobes_den} << 1) <= {1'b0, cyc_num};
  assign idle_go = state_q == IDLE && enable_timer && !disable_timer && !clear_timer;
  assign start   = idle_go && cfg_ok;
  assign adv     = state_q == RUN && !disable_timer && !clear_timer;
  frac_rate_accum #(.ACC_W(ACC_W)) u_accum (
    .clk  (clk),
    .rst  (rst),
    .clr  (clear_timer | start),
    .en   (adv),
    .num  (num_q),
    .den  (den_q),
    .wrap (wrap),
    .half (half)
  );
  // Next state, config latch, bit counter and strobe outputs; clear and disable suppress strobes via adv
  always_comb begin
    bc_inc    = bc_q == fb_q ? BIT_CNT_W'(1) : bc_q + BIT_CNT_W'(1);
    shift_d   = adv && wrap;
    sample_d  = adv && half;
    fc_d      = shift_d && bc_inc == fb_q;
    cfg_err_d = idle_go && !cfg_ok;
    num_d     = start ? cyc_num : num_q;
    den_d     = start ? strobes_den : den_q;
    fb_d      = start ? frame_bits : fb_q;
    os_d      = start ? one_shot : os_q;
    bc_d      = (clear_timer || start) ? '0 : shift_d ? bc_inc : bc_q;
    state_d   = clear_timer                                            ? IDLE  :
                start                                                  ? RUN   :
                (state_q == RUN && disable_timer)                      ? PAUSE :
                (fc_d && os_q)                                         ? IDLE  :
                (state_q == PAUSE && enable_timer && !disable_timer)   ? RUN   :
                                                                         state_q;
    busy_d    = state_d != IDLE;
  end
  // State, latched config and registered outputs; reset discards everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      den_q     <= '0;
      fb_q      <= '0;
      os_q      <= 1'b0;
      bc_q      <= '0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
      fc_q      <= 1'b0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      den_q     <= den_d;
      fb_q      <= fb_d;
      os_q      <= os_d;
      bc_q      <= bc_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      fc_q      <= fc_d;
      cfg_err_q <= cfg_err_d;
      busy_q    <= busy_d;
    end
  end
  assign shift_strobe   = shift_q;
  assign sample_strobe  = sample_q;
  assign bit_count      = bc_q;
  assign frame_complete = fc_q;
  assign busy           = busy_q;
  assign cfg_err        = cfg_err_q;
endmodule
